// File: rtl/ard_bus_link_pkg.sv
// Shared types for the Arduino byte link.
// Holds the link state encoding and the Arduino-side byte width.
package ard_bus_link_pkg;

    localparam int LINK_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        TX_HI,
        TX_HI_REL,
        TX_LO,
        TX_LO_REL,
        RX_HI_REL,
        RX_LO,
        RX_LO_REL,
        RX_HOLD
    } link_state_t;

endpackage

// File: rtl/ard_bus_link_sync.sv
// sync_ff: STAGES-deep flop chain for asynchronous inputs.
// Ports: clk_i, rst_ni (async, active-low, clears to 0), d_i, q_o.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/ard_bus_link.sv
// ard_bus_link: byte-wide 4-phase link between the 16-bit core and the Arduino.
// Core side: tx_word/tx_valid/tx_ready in, rx_word/rx_valid/rx_ready out.
// Arduino side: in_bus/ard_data_ready/data_in_ack, out_bus/data_out_ready/
// ard_receive_ready. Status: busy, error. Macro LINK_TIMEOUT_EN enables the
// handshake watchdog (TIMEOUT_CYC); without it error is tied to 0.
module ard_bus_link
    import ard_bus_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            tx_word,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [15:0]            rx_word,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    input  logic [LINK_BYTE_W-1:0] in_bus,
    input  logic                   ard_data_ready,
    output logic                   data_in_ack,
    output logic [LINK_BYTE_W-1:0] out_bus,
    output logic                   data_out_ready,
    input  logic                   ard_receive_ready,
    output logic                   busy,
    output logic                   error
);

    logic dr_s, rr_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dr (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (ard_data_ready),
        .q_o   (dr_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rr (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (ard_receive_ready),
        .q_o   (rr_s)
    );

    link_state_t            state_q, state_d;
    logic [15:0]            txw_q, txw_d;
    logic [LINK_BYTE_W-1:0] hi_q, hi_d;
    logic [LINK_BYTE_W-1:0] lo_q, lo_d;
    logic [LINK_BYTE_W-1:0] obus_q, obus_d;
    logic                   dor_q, dor_d;
    logic                   ack_q, ack_d;
    logic [15:0]            rxw_q, rxw_d;
    logic                   rxv_q, rxv_d;
    logic                   busy_q;
    logic                   err_q, err_d;

`ifdef LINK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          counting, expired;

    // Waiting in RX_HOLD is core back-pressure, not a stuck handshake.
    assign counting = (state_q != IDLE) && (state_q != RX_HOLD);
    // This edge brings the count to TIMEOUT_CYC.
    assign expired  = counting && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d = state_q;
        txw_d   = txw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        obus_d  = obus_q;
        dor_d   = dor_q;
        ack_d   = ack_q;
        rxw_d   = rxw_q;
        rxv_d   = rxv_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    txw_d   = tx_word;
                    obus_d  = tx_word[15:8];
                    dor_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = TX_HI;
                end else if (dr_s) begin
                    hi_d    = in_bus;
                    ack_d   = 1'b1;
                    state_d = RX_HI_REL;
                end
            end
            TX_HI: begin
                if (rr_s) begin
                    dor_d   = 1'b0;
                    state_d = TX_HI_REL;
                end
            end
            TX_HI_REL: begin
                if (!rr_s) begin
                    obus_d  = txw_q[7:0];
                    dor_d   = 1'b1;
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (rr_s) begin
                    dor_d   = 1'b0;
                    state_d = TX_LO_REL;
                end
            end
            TX_LO_REL: begin
                if (!rr_s) begin
                    state_d = IDLE;
                end
            end
            RX_HI_REL: begin
                if (!dr_s) begin
                    ack_d   = 1'b0;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                if (dr_s) begin
                    lo_d    = in_bus;
                    ack_d   = 1'b1;
                    state_d = RX_LO_REL;
                end
            end
            RX_LO_REL: begin
                if (!dr_s) begin
                    ack_d   = 1'b0;
                    rxw_d   = {hi_q, lo_q};
                    rxv_d   = 1'b1;
                    state_d = RX_HOLD;
                end
            end
            RX_HOLD: begin
                if (rx_ready) begin
                    rxv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef LINK_TIMEOUT_EN
        if (expired) begin
            state_d = IDLE;
            dor_d   = 1'b0;
            ack_d   = 1'b0;
            err_d   = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            txw_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            obus_q  <= '0;
            dor_q   <= 1'b0;
            ack_q   <= 1'b0;
            rxw_q   <= '0;
            rxv_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txw_q   <= txw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            obus_q  <= obus_d;
            dor_q   <= dor_d;
            ack_q   <= ack_d;
            rxw_q   <= rxw_d;
            rxv_q   <= rxv_d;
            busy_q  <= (state_d != IDLE);
            err_q   <= err_d;
        end
    end

`ifdef LINK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign tx_ready       = rst && (state_q == IDLE);
    assign rx_word        = rxw_q;
    assign rx_valid       = rxv_q;
    assign data_in_ack    = ack_q;
    assign out_bus        = obus_q;
    assign data_out_ready = dor_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ard_bus_link.sv
// Self-checking bench for ard_bus_link.
// Table of word transfers plus directed handshake corner sequences.
module tb_ard_bus_link;

`ifdef LINK_TIMEOUT_EN
    localparam int TCYC = 16;
`else
    localparam int TCYC = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] tx_word = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_word;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  in_bus = '0;
    logic        ard_data_ready = 1'b0;
    logic        data_in_ack;
    logic [7:0]  out_bus;
    logic        data_out_ready;
    logic        ard_receive_ready = 1'b0;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ard_bus_link #(.SYNC_STAGES(2), .TIMEOUT_CYC(TCYC)) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_word          (tx_word),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_word          (rx_word),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .in_bus           (in_bus),
        .ard_data_ready   (ard_data_ready),
        .data_in_ack      (data_in_ack),
        .out_bus          (out_bus),
        .data_out_ready   (data_out_ready),
        .ard_receive_ready(ard_receive_ready),
        .busy             (busy),
        .error            (error)
    );

    typedef struct {
        bit          is_tx;
        logic [15:0] stim;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return data_out_ready;
            1:       return data_in_ack;
            2:       return rx_valid;
            default: return tx_ready;
        endcase
    endfunction

    // Bounded wait at negedges; an expired bound shows up as a failed check.
    task automatic wait_sig(input int which, input logic lvl, input string nm);
        logic v;
        for (int i = 0; i < 100; i++) begin
            v = pick(which);
            if (v === lvl) break;
            @(negedge clk);
        end
        v = pick(which);
        chk(nm, 16'(v), 16'(lvl));
    endtask

    task automatic tx_start(input logic [15:0] w);
        wait_sig(3, 1'b1, "tx_ready_before");
        tx_valid = 1'b1;
        tx_word  = w;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic ard_recv(output logic [7:0] b);
        wait_sig(0, 1'b1, "dor_rise");
        b = out_bus;
        ard_receive_ready = 1'b1;
        wait_sig(0, 1'b0, "dor_fall");
        ard_receive_ready = 1'b0;
    endtask

    task automatic ard_send(input logic [7:0] b);
        in_bus = b;
        ard_data_ready = 1'b1;
        wait_sig(1, 1'b1, "ack_rise");
        ard_data_ready = 1'b0;
        wait_sig(1, 1'b0, "ack_fall");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] b1, b2;
        int n;

        vecs[0] = '{1'b1, 16'hA55A, 16'hA55A};
        vecs[1] = '{1'b1, 16'h00FF, 16'h00FF};
        vecs[2] = '{1'b1, 16'hFF00, 16'hFF00};
        vecs[3] = '{1'b0, 16'h1234, 16'h1234};
        vecs[4] = '{1'b0, 16'hFF00, 16'hFF00};
        vecs[5] = '{1'b0, 16'h0001, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_bus", 16'(out_bus), 16'h0000);
        chk("rst_rx_word", rx_word, 16'h0000);
        chk("rst_dor", 16'(data_out_ready), 16'h0);
        chk("rst_ack", 16'(data_in_ack), 16'h0);
        chk("rst_rxv", 16'(rx_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_error", 16'(error), 16'h0);
        chk("rst_tx_ready", 16'(tx_ready), 16'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_tx_ready", 16'(tx_ready), 16'h1);

        // Table of whole-word transfers
        foreach (vecs[k]) begin
            if (vecs[k].is_tx) begin
                tx_start(vecs[k].stim);
                chk("tx_busy", 16'(busy), 16'h1);
                ard_recv(b1);
                ard_recv(b2);
                chk("tx_byte_hi", 16'(b1), 16'(vecs[k].exp[15:8]));
                chk("tx_byte_lo", 16'(b2), 16'(vecs[k].exp[7:0]));
                wait_sig(3, 1'b1, "tx_ready_after");
                chk("tx_hold_out_bus", 16'(out_bus), 16'(vecs[k].exp[7:0]));
            end else begin
                ard_send(vecs[k].stim[15:8]);
                ard_send(vecs[k].stim[7:0]);
                chk("rx_valid_set", 16'(rx_valid), 16'h1);
                chk("rx_word", rx_word, vecs[k].exp);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                chk("rx_valid_clr", 16'(rx_valid), 16'h0);
            end
        end

        // Acknowledge-to-drop latency through the synchroniser
        tx_start(16'hC35A);
        chk("lat_dor_up", 16'(data_out_ready), 16'h1);
        chk("lat_out_hi", 16'(out_bus), 16'h00C3);
        @(negedge clk);
        ard_receive_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_dor_2cyc", 16'(data_out_ready), 16'h1);
        @(negedge clk);
        chk("lat_dor_3cyc", 16'(data_out_ready), 16'h0);
        ard_receive_ready = 1'b0;
        ard_recv(b2);
        chk("lat_out_lo", 16'(b2), 16'h005A);
        wait_sig(3, 1'b1, "lat_tx_ready");

        // Reset mid-TX while the low byte is on the bus
        tx_start(16'h1234);
        ard_recv(b1);
        wait_sig(0, 1'b1, "mid_dor_lo");
        chk("mid_out_lo", 16'(out_bus), 16'h0034);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_bus", 16'(out_bus), 16'h0000);
        chk("arst_dor", 16'(data_out_ready), 16'h0);
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_tx_ready", 16'(tx_ready), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_tx_ready", 16'(tx_ready), 16'h1);

        // Back-pressure in RX_HOLD; third byte becomes the next hi byte
        ard_send(8'h12);
        ard_send(8'h34);
        chk("bp_rx_word", rx_word, 16'h1234);
        in_bus = 8'h56;
        ard_data_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp_no_ack", 16'(data_in_ack), 16'h0);
        chk("bp_rxv_held", 16'(rx_valid), 16'h1);
        chk("bp_word_held", rx_word, 16'h1234);
        chk("bp_tx_ready", 16'(tx_ready), 16'h0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("bp_rxv_clr", 16'(rx_valid), 16'h0);
        wait_sig(1, 1'b1, "bp_third_ack");
        ard_data_ready = 1'b0;
        wait_sig(1, 1'b0, "bp_third_ack_fall");
        ard_send(8'h78);
        chk("bp_new_word", rx_word, 16'h5678);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;

        // tx_valid and synchronised data request in the same IDLE cycle
        in_bus = 8'h9A;
        ard_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_word  = 16'hBEEF;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("pri_dor", 16'(data_out_ready), 16'h1);
        chk("pri_out_hi", 16'(out_bus), 16'h00BE);
        chk("pri_no_ack", 16'(data_in_ack), 16'h0);
        ard_recv(b1);
        chk("pri_no_ack_mid", 16'(data_in_ack), 16'h0);
        ard_recv(b2);
        chk("pri_out_lo", 16'(b2), 16'h00EF);
        wait_sig(1, 1'b1, "pri_rx_ack");
        chk("pri_rx_busy", 16'(tx_ready), 16'h0);
        ard_data_ready = 1'b0;
        wait_sig(1, 1'b0, "pri_rx_ack_fall");
        ard_send(8'hBC);
        chk("pri_rx_word", rx_word, 16'h9ABC);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;

        // Receiver acknowledge stuck low
        tx_start(16'h0F0F);
`ifdef LINK_TIMEOUT_EN
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 16'(n), 16'd16);
        chk("to_error", 16'(error), 16'h1);
        chk("to_dor", 16'(data_out_ready), 16'h0);
        chk("to_idle", 16'(tx_ready), 16'h1);
        tx_start(16'h0101);
        chk("to_err_clr", 16'(error), 16'h0);
        ard_recv(b1);
        ard_recv(b2);
        chk("to_next_lo", 16'(b2), 16'h0001);
`else
        n = 0;
        repeat (200) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_cycles", 16'(n), 16'd200);
        chk("stuck_dor", 16'(data_out_ready), 16'h1);
        chk("stuck_busy", 16'(busy), 16'h1);
        chk("stuck_error", 16'(error), 16'h0);
        chk("stuck_tx_ready", 16'(tx_ready), 16'h0);
        chk("stuck_out_hi", 16'(out_bus), 16'h000F);
        ard_recv(b1);
        ard_recv(b2);
        chk("stuck_done_lo", 16'(b2), 16'h000F);
`endif
        wait_sig(3, 1'b1, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ard_bus_link.md
Name: ard_bus_link

Overview:
- Byte-wide link between the 16-bit serial CPU core and the external Arduino host.
- Splits outgoing 16-bit words (PC, MAR, MDR) into two bytes, high byte first, on out_bus.
- Assembles incoming byte pairs from in_bus into 16-bit words for the core's instruction/MDR path.
- All Arduino-side transfers use a 4-phase request/acknowledge handshake; the Arduino-side inputs are asynchronous and are synchronised with 2 flops.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on ard_data_ready and ard_receive_ready (legal values 2..3).
- TIMEOUT_CYC, 1023: handshake watchdog limit in cycles; used only when LINK_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tx_word  in  16  word to send to the Arduino
- tx_valid  in  1  tx_word is valid
- tx_ready  out  1  link accepts tx_word this cycle
- rx_word  out  16  assembled incoming word, {hi,lo}
- rx_valid  out  1  rx_word is valid
- rx_ready  in  1  core consumes rx_word
- in_bus  in  8  Arduino data byte
- ard_data_ready  in  1  Arduino request: in_bus is valid (async)
- data_in_ack  out  1  link has captured in_bus
- out_bus  out  8  byte to the Arduino
- data_out_ready  out  1  out_bus is valid
- ard_receive_ready  in  1  Arduino acknowledge of out_bus (async)
- busy  out  1  state != IDLE
- error  out  1  handshake timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; synchronisers clear to 0.
  - out_bus=0, rx_word=0; data_out_ready, data_in_ack, rx_valid, busy and error are all 0.
  - tx_ready is forced to 0 while rst=0.
  - Reset mid-transfer drops the transfer silently.
- Signal names below:
  - dr_s: synchronised ard_data_ready.
  - rr_s: synchronised ard_receive_ready.
- All outputs are registered except tx_ready, which equals (state==IDLE).
- States: IDLE, TX_HI, TX_HI_REL, TX_LO, TX_LO_REL, RX_HI_REL, RX_LO, RX_LO_REL, RX_HOLD.
- IDLE:
  - If tx_valid: latch tx_word and go to TX_HI. tx has priority over a simultaneous dr_s.
  - Else if dr_s: capture in_bus into hi byte, set data_in_ack=1, go to RX_HI_REL.
- TX_HI:
  - out_bus=tx_word[15:8], data_out_ready=1.
  - On rr_s=1: clear data_out_ready, go to TX_HI_REL.
- TX_HI_REL: wait for rr_s=0, then go to TX_LO.
- TX_LO / TX_LO_REL: same as the high byte with tx_word[7:0]; then return to IDLE.
- out_bus holds the last byte after the transfer.
- RX_HI_REL: wait for dr_s=0, clear data_in_ack, go to RX_LO.
- RX_LO:
  - On dr_s=1: capture lo byte, data_in_ack=1, go to RX_LO_REL.
- RX_LO_REL: on dr_s=0, clear data_in_ack, load rx_word={hi,lo}, set rx_valid=1, go to RX_HOLD.
- RX_HOLD:
  - rx_word and rx_valid are held until rx_ready=1; then rx_valid=0 and state goes to IDLE.
  - Back-pressure: no new byte is acknowledged in this state.
- Latency:
  - An Arduino edge is acted on at the (SYNC_STAGES+1)th rising clk edge after it.
  - Minimum word transmit time is 4*(SYNC_STAGES+1) cycles.
- A tx_valid that arrives during an RX transfer waits (tx_ready=0); no interleaving.
- in_bus is sampled only in the cycle the capture occurs; the Arduino holds it stable until data_in_ack rises.

Optional Feature:
- Macro LINK_TIMEOUT_EN.
- Defined:
  - A counter resets on every state change and increments in every state except IDLE and RX_HOLD.
  - When the count reaches TIMEOUT_CYC: force IDLE, clear data_out_ready and data_in_ack, set error=1.
  - error is sticky until the next tx accept or rst.
- Undefined: no counter; error is tied to 0; the link waits indefinitely.

Decomposition:
- Shared header types.vh gains:
  - typedef enum logic[3:0] link_state_t holding the nine states.
  - Constant LINK_BYTE_W=8.
- One sub-module, sync_ff (SYNC_STAGES-deep flop chain, async active-low reset to 0). It is instantiated twice, for ard_data_ready and ard_receive_ready.

Test Plan:
1. Reset mid-TX: assert rst=0 while in TX_LO with out_bus=0x34 → out_bus=0x00, data_out_ready=0, state IDLE within the same cycle (asynchronous).
2. TX word 0xA55A: Arduino acks each byte 1 cycle after data_out_ready → out_bus sequence 0xA5 then 0x5A, two data_out_ready pulses, tx_ready=1 again afterwards; rise-to-drop delay is 3 cycles with SYNC_STAGES=2.
3. RX bytes 0x12, 0x34 via 4-phase handshake → rx_word=0x1234, rx_valid=1. Hold rx_ready=0 for 10 cycles and present a third byte → no data_in_ack, rx_valid stays 1. Then rx_ready=1 → IDLE, and the third byte is accepted as a new hi byte.
4. Simultaneous tx_valid and ard_data_ready in IDLE → TX of tx_word completes first; the RX hi byte is acknowledged only after returning to IDLE.
5. LINK_TIMEOUT_EN, TIMEOUT_CYC=16: TX_HI with ard_receive_ready stuck low → after 16 cycles, error=1, data_out_ready=0, IDLE. The next tx accept clears error.
6. Without the macro, the same stimulus as test 5 → link stays in TX_HI for 200 cycles, error=0.
